// File: rtl/ddr3_dfi_pkg.sv
// Shared DFI responder definitions: command encodings, error codes, burst geometry.
package ddr3_dfi_pkg;

  // {ras_n, cas_n, we_n} while cs_n is low
  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_ZQ  = 3'b110,
    CMD_NOP = 3'b111
  } dfi_cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_FIFO_FULL   = 3'd1,
    ERR_NO_CMD      = 3'd2,
    ERR_BANK_CLOSED = 3'd3,
    ERR_ACT_OPEN    = 3'd4,
    ERR_REF_OPEN    = 3'd5
  } dfi_err_e;

  localparam int unsigned BURST_BEATS = 4;
  localparam int unsigned BEAT_W      = 2;
  localparam int unsigned ROW_W       = 15;
  localparam int unsigned BANK_W      = 3;
  localparam int unsigned COL_W       = 7;
  localparam int unsigned NBANK       = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned LANES       = 4;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;
    logic [COL_W-1:0]  col;
  } burst_addr_t;

endpackage

// File: rtl/ddr3_dfi_resp_fifo.sv
// Small pending-command FIFO; head is presented combinationally, push and pop may coincide.
module ddr3_dfi_resp_fifo #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_c;
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_push = push_i && (!full_c || do_pop);
  assign head_c  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ddr3_dfi_responder.sv
// DFI-side PHY+DRAM model: command decode, bank table, masked write capture, fixed-latency reads.
// Define DDR3_DFI_RESP_CHECK_EN to add bank-state protocol checks (error codes 3..5).
module ddr3_dfi_responder
  import ddr3_dfi_pkg::*;
#(
  parameter int unsigned MEM_AW     = 12,
  parameter int unsigned DFI_RD_LAT = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [14:0] dfi_address_i,
  input  logic [2:0]  dfi_bank_i,
  input  logic        dfi_cs_n_i,
  input  logic        dfi_ras_n_i,
  input  logic        dfi_cas_n_i,
  input  logic        dfi_we_n_i,
  input  logic        dfi_cke_i,
  input  logic        dfi_reset_n_i,
  input  logic        dfi_odt_i,
  input  logic [31:0] dfi_wrdata_i,
  input  logic        dfi_wrdata_en_i,
  input  logic [3:0]  dfi_wrdata_mask_i,
  input  logic        dfi_rddata_en_i,
  output logic [31:0] dfi_rddata_o,
  output logic        dfi_rddata_valid_o,
  output logic [1:0]  dfi_rddata_dnv_o,
  output logic        err_o,
  output logic [2:0]  err_code_o
);
  localparam int unsigned ENT_W = $bits(burst_addr_t);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

  logic unused_odt;
  assign unused_odt = dfi_odt_i;

  // Command decode
  dfi_cmd_e    cmd_c;
  logic        cmd_en, is_act, is_pre, is_rd, is_wr;
  assign cmd_en = !dfi_cs_n_i && dfi_cke_i && dfi_reset_n_i;
  assign cmd_c  = dfi_cmd_e'({dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i});
  assign is_act = cmd_en && (cmd_c == CMD_ACT);
  assign is_pre = cmd_en && (cmd_c == CMD_PRE);
  assign is_rd  = cmd_en && (cmd_c == CMD_RD);
  assign is_wr  = cmd_en && (cmd_c == CMD_WR);

  logic [ROW_W-1:0] open_row_q [NBANK];
  logic [NBANK-1:0] bank_open_q;
  burst_addr_t      entry;

  always_comb begin
    entry.bank = dfi_bank_i;
    entry.col  = dfi_address_i[9:3];
`ifdef DDR3_DFI_RESP_CHECK_EN
    entry.row  = bank_open_q[dfi_bank_i] ? open_row_q[dfi_bank_i] : '0;
`else
    entry.row  = open_row_q[dfi_bank_i];
`endif
  end

  // Pending burst FIFOs and beat tracking
  logic [ENT_W-1:0]  wr_head, rd_head;
  logic              wr_full, wr_empty, rd_full, rd_empty;
  logic [BEAT_W-1:0] wbeat_q, rbeat_q;
  logic              wr_beat_en, rd_beat_en, wr_hit, rd_hit, wr_pop, rd_pop;

  assign wr_beat_en = dfi_wrdata_en_i && dfi_reset_n_i;
  assign rd_beat_en = dfi_rddata_en_i && dfi_reset_n_i;
  assign wr_hit     = wr_beat_en && !wr_empty;
  assign rd_hit     = rd_beat_en && !rd_empty;
  assign wr_pop     = wr_hit && (wbeat_q == LAST_BEAT);
  assign rd_pop     = rd_hit && (rbeat_q == LAST_BEAT);

  ddr3_dfi_resp_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(!dfi_reset_n_i), .push_i(is_wr), .pop_i(wr_pop),
    .din_i(entry), .head_c(wr_head), .full_c(wr_full), .empty_c(wr_empty)
  );

  ddr3_dfi_resp_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(!dfi_reset_n_i), .push_i(is_rd), .pop_i(rd_pop),
    .din_i(entry), .head_c(rd_head), .full_c(rd_full), .empty_c(rd_empty)
  );

  // Local RAM; high row bits alias when the RAM is smaller than the DRAM space
  logic [DATA_W-1:0] mem_q [2**MEM_AW];
  logic [MEM_AW-1:0] waddr, raddr;
  logic [DATA_W-1:0] wr_word, rd_word;

  assign waddr   = MEM_AW'({wr_head, wbeat_q});
  assign raddr   = MEM_AW'({rd_head, rbeat_q});
  assign rd_word = rd_hit ? mem_q[raddr] : '0;

  always_comb begin
    wr_word = mem_q[waddr];
    for (int l = 0; l < LANES; l++) begin
      if (!dfi_wrdata_mask_i[l]) wr_word[8*l +: 8] = dfi_wrdata_i[8*l +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_hit) mem_q[waddr] <= wr_word;
  end

  // Error classification; lowest code wins when several fire together
  logic     overflow, underrun;
  dfi_err_e err_c;
  assign overflow = (is_wr && wr_full && !wr_pop) || (is_rd && rd_full && !rd_pop);
  assign underrun = (wr_beat_en && wr_empty) || (rd_beat_en && rd_empty);

  always_comb begin
    err_c = ERR_NONE;
`ifdef DDR3_DFI_RESP_CHECK_EN
    if (cmd_en && (cmd_c == CMD_REF) && (|bank_open_q)) err_c = ERR_REF_OPEN;
    if (is_act && bank_open_q[dfi_bank_i])               err_c = ERR_ACT_OPEN;
    if ((is_rd || is_wr) && !bank_open_q[dfi_bank_i])    err_c = ERR_BANK_CLOSED;
`endif
    if (underrun) err_c = ERR_NO_CMD;
    if (overflow) err_c = ERR_FIFO_FULL;
  end

  logic [DFI_RD_LAT-1:0] pipe_v_q;
  logic [DATA_W-1:0]     pipe_d_q [DFI_RD_LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_open_q <= '0;
      for (int b = 0; b < NBANK; b++) open_row_q[b] <= '0;
      wbeat_q    <= '0;
      rbeat_q    <= '0;
      err_o      <= 1'b0;
      err_code_o <= '0;
      pipe_v_q   <= '0;
      for (int i = 0; i < DFI_RD_LAT; i++) pipe_d_q[i] <= '0;
    end else begin
      if (!dfi_reset_n_i) begin
        bank_open_q <= '0;
        for (int b = 0; b < NBANK; b++) open_row_q[b] <= '0;
        wbeat_q <= '0;
        rbeat_q <= '0;
      end else begin
        if (is_act) begin
          open_row_q[dfi_bank_i]  <= dfi_address_i;
          bank_open_q[dfi_bank_i] <= 1'b1;
        end else if (is_pre) begin
          if (dfi_address_i[10]) bank_open_q <= '0;
          else                   bank_open_q[dfi_bank_i] <= 1'b0;
        end
        if (wr_hit) wbeat_q <= wbeat_q + BEAT_W'(1);
        if (rd_hit) rbeat_q <= rbeat_q + BEAT_W'(1);
      end
      if (!err_o && (err_c != ERR_NONE)) begin
        err_o      <= 1'b1;
        err_code_o <= err_c;
      end
      pipe_v_q[0] <= rd_beat_en;
      pipe_d_q[0] <= rd_word;
      for (int i = 1; i < DFI_RD_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_d_q[i] <= pipe_d_q[i-1];
      end
    end
  end

  assign dfi_rddata_o       = pipe_d_q[DFI_RD_LAT-1];
  assign dfi_rddata_valid_o = pipe_v_q[DFI_RD_LAT-1];
  assign dfi_rddata_dnv_o   = 2'b00;

endmodule
